// File: rtl/cim_pkg.sv
// cim_pkg: shared constants and FSM state type for the CIM GeMV controller.
package cim_pkg;
  localparam int CIM_COLS = 8;
  localparam int CIM_BANK_BYTES = 128;
  localparam int CIM_STEP_BYTES = 8;
  localparam int CIM_ADC_MSB = 13;
  localparam int CIM_ADC_BITS = 6;
  typedef enum logic [2:0] {IDLE, LOAD, CLEAR, COMPUTE, SETTLE, DRAIN, DONE} cim_state_t;
endpackage

// File: rtl/cim_wload_addr_gen.sv
// cim_wload_addr_gen: column/row counter producing the weight-load byte address.
module cim_wload_addr_gen
  import cim_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_init,
  input  logic       i_adv,
  input  logic [4:0] i_num_steps,
  output logic [9:0] o_addr,
  output logic       o_last
);
  logic [2:0] r_col;
  logic [4:0] r_k;
  logic       w_k_last;
  // each column bank holds 2*num_steps words of four bytes
  assign w_k_last = {1'b0, r_k} == {i_num_steps, 1'b0} - 6'd1;
  assign o_last = w_k_last && r_col == 3'(CIM_COLS - 1);
  assign o_addr = 10'(int'(r_col) * CIM_BANK_BYTES + 4 * int'(r_k));
  always_ff @(posedge clk) begin
    if (rst || i_init) begin
      r_col <= '0;
      r_k <= '0;
    end else if (i_adv) begin
      r_k <= w_k_last ? 5'd0 : r_k + 5'd1;
      r_col <= w_k_last ? r_col + 3'd1 : r_col;
    end
  end
endmodule

// File: rtl/cim_gemv_ctrl.sv
// cim_gemv_ctrl: CIM macro sequencer running load/clear/compute/drain per job.
// CIM_ZERO_SKIP_EN: all-zero activation beats are consumed without a macro cycle.
module cim_gemv_ctrl
  import cim_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        load_w,
  input  logic [4:0]  num_steps,
  output logic        busy,
  output logic        done,
  input  logic        wt_valid,
  output logic        wt_ready,
  input  logic [31:0] wt_data,
  input  logic        act_valid,
  output logic        act_ready,
  input  logic [31:0] act_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic [2:0]  res_idx,
  output logic        cim_cs,
  output logic        cim_web,
  output logic        cim_cimeb,
  output logic        cim_partial_sum_eb,
  output logic        cim_reset_output_reg,
  output logic [3:0]  cim_output_reg,
  output logic [31:0] cim_address,
  output logic [31:0] cim_input_data,
  input  logic [31:0] cim_output
);
  cim_state_t r_state, w_next;
  logic [4:0] r_n, r_step;
  logic [2:0] r_c;
  logic r_sel_ok, r_busy, r_done, r_wt_ready, r_act_ready, r_res_valid;
  logic r_cs, r_web, r_cimeb, r_pse, r_rst_acc;
  logic [31:0] r_res_data, r_addr, r_data;
  logic w_cs, w_web, w_cimeb, w_pse, w_rst_acc, w_wt_acc, w_act_acc, w_gen_last, w_unused;
  logic [31:0] w_addr, w_data;
  logic [9:0] w_gen_addr;
  assign w_wt_acc = wt_valid && r_wt_ready;
  assign w_act_acc = act_valid && r_act_ready;
  assign w_unused = ^{cim_output[31:CIM_ADC_MSB+1], cim_output[CIM_ADC_MSB-CIM_ADC_BITS:0]};
  cim_wload_addr_gen u_addr_gen (
    .clk(clk), .rst(rst), .i_init(r_state == IDLE), .i_adv(w_wt_acc),
    .i_num_steps(r_n), .o_addr(w_gen_addr), .o_last(w_gen_last)
  );
  always_comb begin
    w_next = r_state;
    w_cs = 1'b0;
    w_web = 1'b0;
    w_cimeb = 1'b1;
    w_pse = 1'b0;
    w_rst_acc = 1'b0;
    w_addr = r_addr;
    w_data = r_data;
    case (r_state)
      IDLE: if (start) w_next = (load_w && num_steps != 5'd0) ? LOAD : CLEAR;
      LOAD: if (w_wt_acc) begin
        w_cs = 1'b1;
        w_web = 1'b1;
        w_addr = 32'(w_gen_addr);
        w_data = wt_data;
        w_next = w_gen_last ? CLEAR : LOAD;
      end
      CLEAR: begin
        w_cs = 1'b1;
        w_cimeb = 1'b0;
        w_rst_acc = 1'b1;
        w_next = (r_n == 5'd0) ? DRAIN : COMPUTE;
      end
      COMPUTE: if (w_act_acc) begin
`ifdef CIM_ZERO_SKIP_EN
        w_cs = act_data != 32'd0;
`else
        w_cs = 1'b1;
`endif
        w_cimeb = !w_cs;
        w_pse = w_cs;
        w_addr = 32'(CIM_STEP_BYTES * int'(r_step));
        w_data = act_data;
        w_next = (r_step == r_n - 5'd1) ? SETTLE : COMPUTE;
      end
      SETTLE: w_next = DRAIN;
      DRAIN: if (r_res_valid && res_ready && r_c == 3'(CIM_COLS - 1)) w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      {r_n, r_step, r_c, r_sel_ok} <= '0;
      {r_busy, r_done, r_wt_ready, r_act_ready, r_res_valid} <= '0;
      {r_cs, r_web, r_pse, r_rst_acc} <= '0;
      r_cimeb <= 1'b1;
      {r_res_data, r_addr, r_data} <= '0;
    end else begin
      r_state <= w_next;
      r_busy <= w_next != IDLE;
      r_done <= w_next == DONE;
      r_wt_ready <= w_next == LOAD;
      r_act_ready <= w_next == COMPUTE;
      {r_cs, r_web, r_cimeb, r_pse, r_rst_acc} <= {w_cs, w_web, w_cimeb, w_pse, w_rst_acc};
      r_addr <= w_addr;
      r_data <= w_data;
      if (r_state == IDLE) begin
        {r_step, r_c, r_sel_ok} <= '0;
        if (start) r_n <= num_steps;
      end
      if (w_act_acc) r_step <= r_step + 5'd1;
      // select settles one cycle before the quantised column value is captured
      if (r_state == DRAIN) begin
        if (r_res_valid) begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_sel_ok <= 1'b0;
            r_c <= r_c + 3'd1;
          end
        end else if (r_sel_ok) begin
          r_res_valid <= 1'b1;
          r_res_data <= {{(32-CIM_ADC_BITS){cim_output[CIM_ADC_MSB]}}, cim_output[CIM_ADC_MSB -: CIM_ADC_BITS]};
        end else
          r_sel_ok <= 1'b1;
      end
    end
  end
  assign busy = r_busy;
  assign done = r_done;
  assign wt_ready = r_wt_ready;
  assign act_ready = r_act_ready;
  assign res_valid = r_res_valid;
  assign res_data = r_res_data;
  assign res_idx = r_c;
  assign cim_cs = r_cs;
  assign cim_web = r_web;
  assign cim_cimeb = r_cimeb;
  assign cim_partial_sum_eb = r_pse;
  assign cim_reset_output_reg = r_rst_acc;
  assign cim_output_reg = {1'b0, r_c};
  assign cim_address = r_addr;
  assign cim_input_data = r_data;
endmodule
